l3fwd_c2h_gen: RTL and testbench

//  C2H packet generator for the L3 forwarding latency test; drives the s_axis_c2h_*_i side of the latency counter stage.

---
 rtl/l3fwd_pkg.sv | 23 ++
 rtl/l3fwd_c2h_pattern.sv | 17 +
 rtl/l3fwd_c2h_gen.sv | 168 ++++++++++++++++
 tb/tb_l3fwd_c2h_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/l3fwd_pkg.sv
// Shared types and length helpers for the L3 forwarding C2H packet generator.
package l3fwd_pkg;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   function automatic int bpb_f(input int dw);
      return dw / 8;
   endfunction

   // Beats needed for len bytes; widened so len near 64K cannot overflow the round-up.
   function automatic logic [15:0] beats_f(input logic [15:0] len, input int dw);
      logic [16:0] t;
      t = {1'b0, len} + 17'(bpb_f(dw) - 1);
      return 16'(t / 17'(bpb_f(dw)));
   endfunction

   function automatic logic [5:0] mty_f(input logic [15:0] len, input int dw);
      logic [16:0] t;
      t = 17'(beats_f(len, dw)) * 17'(bpb_f(dw)) - {1'b0, len};
      return 6'(t);
   endfunction

endpackage

// File: rtl/l3fwd_c2h_pattern.sv
// Deterministic payload: 16-bit lane i of beat b carries b*LANES + i.
module l3fwd_c2h_pattern #(
   parameter int C_DATA_WIDTH = 256
) (
   input  logic [15:0]             beat,
   output logic [C_DATA_WIDTH-1:0] data
);
   localparam int LANES = C_DATA_WIDTH / 16;

   logic [15:0] base;
   assign base = beat * 16'(LANES);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign data[i*16 +: 16] = base + 16'(i);
   end

endmodule

// File: rtl/l3fwd_c2h_gen.sv
// C2H packet generator: fixed-length packets, round-robin over a queue range.
// Define L3FWD_C2H_GEN_GAP_EN to insert gen_gap idle cycles between packets.
module l3fwd_c2h_gen
   import l3fwd_pkg::*;
#(
   parameter int C_DATA_WIDTH = 256,
   parameter int QID_WIDTH    = 11,
   parameter int C_PKT_WIDTH  = 32,
   parameter int TCQ          = 1
) (
   input  logic                    user_clk,
   input  logic                    user_reset,
   input  logic                    gen_start,
   input  logic                    gen_stop,
   input  logic [15:0]             gen_len,
   input  logic [QID_WIDTH-1:0]    gen_qid_base,
   input  logic [QID_WIDTH-1:0]    gen_num_q,
   input  logic [C_PKT_WIDTH-1:0]  gen_num_pkt,
   input  logic                    gen_dis_cmpt,
   input  logic [7:0]              gen_gap,
   output logic [C_DATA_WIDTH-1:0] s_axis_c2h_tdata,
   output logic                    s_axis_c2h_ctrl_marker,
   output logic [15:0]             s_axis_c2h_ctrl_len,
   output logic [QID_WIDTH-1:0]    s_axis_c2h_ctrl_qid,
   output logic                    s_axis_c2h_ctrl_user_trig,
   output logic                    s_axis_c2h_ctrl_dis_cmpt,
   output logic                    s_axis_c2h_ctrl_imm_data,
   output logic                    s_axis_c2h_tvalid,
   input  logic                    s_axis_c2h_tready,
   output logic                    s_axis_c2h_tlast,
   output logic [5:0]              s_axis_c2h_mty,
   output logic                    gen_busy,
   output logic [C_PKT_WIDTH-1:0]  gen_pkt_cnt,
   output logic                    gen_cfg_err
);
   state_t                 state;
   logic [15:0]            len_r, beats_r, beat;
   logic [5:0]             mty_r;
   logic [QID_WIDTH-1:0]   qid_base_r, num_q_r, q_idx, q_inc;
   logic [C_PKT_WIDTH-1:0] num_pkt_r, pkt_cnt, pkt_inc;
   logic                   dis_r, stop_pending, tvalid_r;
   logic                   accept, last_beat, run_done;
   logic [C_DATA_WIDTH-1:0] pattern;
   logic                   unused_ok;
`ifdef L3FWD_C2H_GEN_GAP_EN
   logic [7:0]             gap_r, gap_cnt;
   assign unused_ok = (TCQ != 0);
`else
   assign unused_ok = ^{gen_gap, TCQ != 0};
`endif

   assign accept    = tvalid_r & s_axis_c2h_tready;
   assign last_beat = (beat == beats_r - 16'd1);
   assign pkt_inc   = pkt_cnt + C_PKT_WIDTH'(1);
   assign q_inc     = q_idx + QID_WIDTH'(1);
   // A stop arriving on the tlast cycle itself still ends the run there.
   assign run_done  = stop_pending | gen_stop | ((num_pkt_r != '0) && (pkt_inc == num_pkt_r));

   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         state        <= IDLE;
         len_r        <= '0;
         beats_r      <= '0;
         mty_r        <= '0;
         beat         <= '0;
         qid_base_r   <= '0;
         num_q_r      <= '0;
         q_idx        <= '0;
         num_pkt_r    <= '0;
         pkt_cnt      <= '0;
         dis_r        <= 1'b0;
         stop_pending <= 1'b0;
         tvalid_r     <= 1'b0;
         gen_cfg_err  <= 1'b0;
`ifdef L3FWD_C2H_GEN_GAP_EN
         gap_r        <= '0;
         gap_cnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (gen_start) begin
                  if (gen_len == 16'd0) begin
                     gen_cfg_err <= 1'b1;
                  end else begin
                     state        <= SEND;
                     len_r        <= gen_len;
                     beats_r      <= beats_f(gen_len, C_DATA_WIDTH);
                     mty_r        <= mty_f(gen_len, C_DATA_WIDTH);
                     beat         <= '0;
                     qid_base_r   <= gen_qid_base;
                     num_q_r      <= (gen_num_q == '0) ? QID_WIDTH'(1) : gen_num_q;
                     q_idx        <= '0;
                     num_pkt_r    <= gen_num_pkt;
                     pkt_cnt      <= '0;
                     dis_r        <= gen_dis_cmpt;
                     stop_pending <= 1'b0;
                     tvalid_r     <= 1'b1;
                     gen_cfg_err  <= 1'b0;
`ifdef L3FWD_C2H_GEN_GAP_EN
                     gap_r        <= gen_gap;
`endif
                  end
               end
            end
            SEND: begin
               if (gen_stop) stop_pending <= 1'b1;
               if (accept) begin
                  if (last_beat) begin
                     beat  <= '0;
                     q_idx <= (q_inc == num_q_r) ? '0 : q_inc;
                     if (pkt_cnt != '1) pkt_cnt <= pkt_inc;
                     if (run_done) begin
                        state    <= IDLE;
                        tvalid_r <= 1'b0;
                     end
`ifdef L3FWD_C2H_GEN_GAP_EN
                     else if (gap_r != 8'd0) begin
                        state    <= GAP;
                        tvalid_r <= 1'b0;
                        gap_cnt  <= gap_r;
                     end
`endif
                  end else begin
                     beat <= beat + 16'd1;
                  end
               end
            end
`ifdef L3FWD_C2H_GEN_GAP_EN
            GAP: begin
               if (gen_stop || stop_pending) begin
                  state <= IDLE;
               end else if (gap_cnt == 8'd1) begin
                  state    <= SEND;
                  tvalid_r <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               tvalid_r <= 1'b0;
            end
         endcase
      end
   end

   l3fwd_c2h_pattern #(.C_DATA_WIDTH(C_DATA_WIDTH)) u_pattern (
      .beat (beat),
      .data (pattern)
   );

   // Data and last-beat sideband are gated so idle/reset outputs read as zero.
   assign s_axis_c2h_tdata          = tvalid_r ? pattern : '0;
   assign s_axis_c2h_tvalid         = tvalid_r;
   assign s_axis_c2h_tlast          = tvalid_r & last_beat;
   assign s_axis_c2h_mty            = (tvalid_r & last_beat) ? mty_r : 6'd0;
   assign s_axis_c2h_ctrl_len       = len_r;
   assign s_axis_c2h_ctrl_qid       = qid_base_r + q_idx;
   assign s_axis_c2h_ctrl_dis_cmpt  = dis_r;
   assign s_axis_c2h_ctrl_marker    = 1'b0;
   assign s_axis_c2h_ctrl_user_trig = 1'b0;
   assign s_axis_c2h_ctrl_imm_data  = 1'b0;
   assign gen_busy                  = (state != IDLE);
   assign gen_pkt_cnt               = pkt_cnt;

endmodule

// File: tb/tb_l3fwd_c2h_gen.sv
// Directed bench for l3fwd_c2h_gen at 256-bit datapath; gap step needs L3FWD_C2H_GEN_GAP_EN.
module tb_l3fwd_c2h_gen;
   localparam int DW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          gen_start, gen_stop, gen_dis_cmpt;
   logic [15:0]   gen_len;
   logic [10:0]   gen_qid_base, gen_num_q;
   logic [31:0]   gen_num_pkt;
   logic [7:0]    gen_gap;
   logic [DW-1:0] tdata;
   logic          marker, user_trig, dis_cmpt, imm_data, tvalid, tready, tlast;
   logic [15:0]   ctrl_len;
   logic [10:0]   ctrl_qid;
   logic [5:0]    mty;
   logic          busy, cfg_err;
   logic [31:0]   pkt_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   l3fwd_c2h_gen #(.C_DATA_WIDTH(DW), .QID_WIDTH(11), .C_PKT_WIDTH(32), .TCQ(1)) dut (
      .user_clk                  (clk),
      .user_reset                (rst),
      .gen_start                 (gen_start),
      .gen_stop                  (gen_stop),
      .gen_len                   (gen_len),
      .gen_qid_base              (gen_qid_base),
      .gen_num_q                 (gen_num_q),
      .gen_num_pkt               (gen_num_pkt),
      .gen_dis_cmpt              (gen_dis_cmpt),
      .gen_gap                   (gen_gap),
      .s_axis_c2h_tdata          (tdata),
      .s_axis_c2h_ctrl_marker    (marker),
      .s_axis_c2h_ctrl_len       (ctrl_len),
      .s_axis_c2h_ctrl_qid       (ctrl_qid),
      .s_axis_c2h_ctrl_user_trig (user_trig),
      .s_axis_c2h_ctrl_dis_cmpt  (dis_cmpt),
      .s_axis_c2h_ctrl_imm_data  (imm_data),
      .s_axis_c2h_tvalid         (tvalid),
      .s_axis_c2h_tready         (tready),
      .s_axis_c2h_tlast          (tlast),
      .s_axis_c2h_mty            (mty),
      .gen_busy                  (busy),
      .gen_pkt_cnt               (pkt_cnt),
      .gen_cfg_err               (cfg_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse gen_start for one edge; returns at the following negedge.
   task automatic start_run(input logic [15:0] len, input logic [10:0] base,
                            input logic [10:0] nq, input logic [31:0] np);
      gen_len = len; gen_qid_base = base; gen_num_q = nq; gen_num_pkt = np;
      gen_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      gen_start = 1'b0;
   endtask

   initial begin
      logic [7:0] rdy_pat;
      int exp_b;
      rst = 1'b1; gen_start = 1'b0; gen_stop = 1'b0; gen_dis_cmpt = 1'b0;
      gen_len = '0; gen_qid_base = '0; gen_num_q = '0; gen_num_pkt = '0;
      gen_gap = '0; tready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_tdata", 64'(|tdata), 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_consts", {marker, user_trig, imm_data}, 0);
      rst = 1'b0;
      @(negedge clk);

      // 3 packets x 2 beats over queues 5,6
      gen_dis_cmpt = 1'b1;
      start_run(16'd64, 11'd5, 11'd2, 32'd3);
      for (int p = 0; p < 3; p++) begin
         for (int b = 0; b < 2; b++) begin
            chk("t1_tvalid", tvalid, 1);
            chk("t1_qid", ctrl_qid, 64'(5 + (p % 2)));
            chk("t1_tlast", tlast, 64'(b == 1));
            chk("t1_mty", mty, 0);
            chk("t1_lane0", tdata[15:0], 64'(b * 16));
            chk("t1_len", ctrl_len, 64);
            chk("t1_dis", dis_cmpt, 1);
            @(negedge clk);
         end
      end
      chk("t1_end_tvalid", tvalid, 0);
      chk("t1_end_busy", busy, 0);
      chk("t1_end_cnt", pkt_cnt, 3);

      // 33 bytes: 2 beats, 31 empty bytes on the last
      gen_dis_cmpt = 1'b0;
      start_run(16'd33, 11'd0, 11'd1, 32'd1);
      chk("t2_b0_tlast", tlast, 0);
      chk("t2_b0_mty", mty, 0);
      chk("t2_b0_lane0", tdata[15:0], 0);
      @(negedge clk);
      chk("t2_b1_tlast", tlast, 1);
      chk("t2_b1_mty", mty, 31);
      chk("t2_b1_len", ctrl_len, 33);
      chk("t2_b1_lane0", tdata[15:0], 16);
      chk("t2_b1_lane1", tdata[31:16], 17);
      @(negedge clk);
      chk("t2_end_tvalid", tvalid, 0);

      // backpressure: 3-beat packet, num_q=0 acts as 1
      rdy_pat = 8'b1001_0100;
      exp_b = 0;
      start_run(16'd96, 11'd7, 11'd0, 32'd1);
      for (int c = 0; c < 8; c++) begin
         tready = rdy_pat[c];
         chk("t3_tvalid", tvalid, 1);
         chk("t3_lane0", tdata[15:0], 64'(exp_b * 16));
         chk("t3_tlast", tlast, 64'(exp_b == 2));
         chk("t3_qid", ctrl_qid, 7);
         chk("t3_cnt", pkt_cnt, 0);
         @(negedge clk);
         if (rdy_pat[c]) exp_b++;
      end
      tready = 1'b1;
      chk("t3_end_tvalid", tvalid, 0);
      chk("t3_end_cnt", pkt_cnt, 1);

      // unbounded run stopped during beat 1 of a 4-beat packet
      start_run(16'd128, 11'd0, 11'd1, 32'd0);
      chk("t4_b0_lane0", tdata[15:0], 0);
      @(negedge clk);
      chk("t4_b1_lane0", tdata[15:0], 16);
      gen_stop = 1'b1;
      @(negedge clk);
      gen_stop = 1'b0;
      chk("t4_b2_lane0", tdata[15:0], 32);
      chk("t4_b2_busy", busy, 1);
      @(negedge clk);
      chk("t4_b3_tlast", tlast, 1);
      @(negedge clk);
      chk("t4_end_tvalid", tvalid, 0);
      chk("t4_end_busy", busy, 0);
      chk("t4_end_cnt", pkt_cnt, 1);

      // illegal length, then a legal 8-byte packet
      start_run(16'd0, 11'd0, 11'd1, 32'd1);
      chk("t5_err_tvalid", tvalid, 0);
      chk("t5_err_flag", cfg_err, 1);
      chk("t5_err_busy", busy, 0);
      start_run(16'd8, 11'd0, 11'd1, 32'd1);
      chk("t5_ok_err", cfg_err, 0);
      chk("t5_ok_tvalid", tvalid, 1);
      chk("t5_ok_tlast", tlast, 1);
      chk("t5_ok_mty", mty, 24);
      @(negedge clk);
      chk("t5_end_tvalid", tvalid, 0);

      // asynchronous reset mid-packet, then a fresh run
      start_run(16'd128, 11'd3, 11'd1, 32'd1);
      @(negedge clk);
      chk("t6_b1_lane0", tdata[15:0], 16);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_tvalid", tvalid, 0);
      chk("t6_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_run(16'd128, 11'd3, 11'd1, 32'd1);
      chk("t6_new_lane0", tdata[15:0], 0);
      chk("t6_new_qid", ctrl_qid, 3);
      chk("t6_new_cnt", pkt_cnt, 0);
      repeat (4) @(negedge clk);
      chk("t6_end_cnt", pkt_cnt, 1);
      chk("t6_end_tvalid", tvalid, 0);

`ifdef L3FWD_C2H_GEN_GAP_EN
      // gap of 3 idle cycles between single-beat packets
      gen_gap = 8'd3;
      start_run(16'd32, 11'd0, 11'd1, 32'd2);
      chk("t7_p0_tlast", tlast, 1);
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         chk("t7_gap_tvalid", tvalid, 0);
      end
      @(negedge clk);
      chk("t7_p1_tvalid", tvalid, 1);
      chk("t7_p1_tlast", tlast, 1);
      @(negedge clk);
      chk("t7_end_tvalid", tvalid, 0);
      chk("t7_end_cnt", pkt_cnt, 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
